// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter and sequencer for the single-port,
// parity-protected memory my_mem. Commands from port 0 (DMA/test engine) and
// port 1 (CPU bus) are serialised onto the memory strobes. Read data is routed
// back to the issuing port. The stored parity of every read word is checked.
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   reqN/weN/addrN/wdataN   command from port N (held until gntN)
//   gntN                    one-cycle pulse, command accepted (ACCESS cycle)
//   rvalidN                 one-cycle pulse, rdata belongs to port N
//   rdata, parity_err       shared read payload and its parity status
//   err_count               saturating parity error count
//   mem_write/mem_read/mem_addr/mem_data_in   memory command pins
//   mem_data_out            memory word {parity, data}, valid the cycle after a read
module mem_arbiter #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req0,
   input  logic                  req1,
   input  logic                  we0,
   input  logic                  we1,
   input  logic [ADDR_WIDTH-1:0] addr0,
   input  logic [ADDR_WIDTH-1:0] addr1,
   input  logic [DATA_WIDTH-1:0] wdata0,
   input  logic [DATA_WIDTH-1:0] wdata1,
   output logic                  gnt0,
   output logic                  gnt1,
   output logic                  rvalid0,
   output logic                  rvalid1,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  parity_err,
   output logic [7:0]            err_count,
   output logic                  mem_write,
   output logic                  mem_read,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_data_in,
   input  logic [DATA_WIDTH:0]   mem_data_out
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t                state, state_nx;
   logic                  last_gnt, last_gnt_nx;
   logic                  owner, owner_nx;     // port whose read is in flight
   logic                  gnt0_nx, gnt1_nx, rvalid0_nx, rvalid1_nx;
   logic [DATA_WIDTH-1:0] rdata_nx;
   logic                  parity_err_nx;
   logic [7:0]            err_count_nx;
   logic                  mem_write_nx, mem_read_nx;
   logic [ADDR_WIDTH-1:0] mem_addr_nx;
   logic [DATA_WIDTH-1:0] mem_data_in_nx;
   logic                  win, win_we, bad;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         last_gnt    <= 1'b1;
         owner       <= 1'b0;
         gnt0        <= 1'b0;
         gnt1        <= 1'b0;
         rvalid0     <= 1'b0;
         rvalid1     <= 1'b0;
         rdata       <= '0;
         parity_err  <= 1'b0;
         err_count   <= '0;
         mem_write   <= 1'b0;
         mem_read    <= 1'b0;
         mem_addr    <= '0;
         mem_data_in <= '0;
      end else begin
         state       <= state_nx;
         last_gnt    <= last_gnt_nx;
         owner       <= owner_nx;
         gnt0        <= gnt0_nx;
         gnt1        <= gnt1_nx;
         rvalid0     <= rvalid0_nx;
         rvalid1     <= rvalid1_nx;
         rdata       <= rdata_nx;
         parity_err  <= parity_err_nx;
         err_count   <= err_count_nx;
         mem_write   <= mem_write_nx;
         mem_read    <= mem_read_nx;
         mem_addr    <= mem_addr_nx;
         mem_data_in <= mem_data_in_nx;
      end
   end

   always_comb begin
      state_nx        = state;
      last_gnt_nx     = last_gnt;
      owner_nx        = owner;
      gnt0_nx         = 1'b0;
      gnt1_nx         = 1'b0;
      rvalid0_nx      = 1'b0;
      rvalid1_nx      = 1'b0;
      rdata_nx        = rdata;
      parity_err_nx   = 1'b0;
      err_count_nx    = err_count;
      mem_write_nx    = 1'b0;
      mem_read_nx     = 1'b0;
      mem_addr_nx     = mem_addr;
      mem_data_in_nx  = mem_data_in;
      // Under contention the port that was not granted last wins.
      win    = (req0 && req1) ? ~last_gnt : req1;
      win_we = win ? we1 : we0;
      // Good words carry an odd number of ones across all bits.
      bad    = ~(^mem_data_out);

      case (state)
         IDLE: begin
            if (req0 || req1) begin
               owner_nx       = win;
               last_gnt_nx    = win;
               gnt0_nx        = ~win;
               gnt1_nx        = win;
               mem_write_nx   = win_we;
               mem_read_nx    = ~win_we;
               mem_addr_nx    = win ? addr1 : addr0;
               mem_data_in_nx = win ? wdata1 : wdata0;
               state_nx       = ACCESS;
            end
         end
         // Strobes live only here; the registered defaults drop them next cycle.
         ACCESS: state_nx = mem_read ? RESP : IDLE;
         RESP: begin
            rdata_nx      = mem_data_out[DATA_WIDTH-1:0];
            rvalid0_nx    = ~owner;
            rvalid1_nx    = owner;
            parity_err_nx = bad;
            if (bad && err_count != 8'hFF) err_count_nx = err_count + 8'd1;
            state_nx      = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural my_mem model.
module tb_mem_arbiter;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0, req1, we0, we1;
   logic [15:0] addr0, addr1;
   logic [7:0]  wdata0, wdata1;
   logic        gnt0, gnt1, rvalid0, rvalid1;
   logic [7:0]  rdata;
   logic        parity_err;
   logic [7:0]  err_count;
   logic        mem_write, mem_read;
   logic [15:0] mem_addr;
   logic [7:0]  mem_data_in;
   logic [8:0]  mem_data_out;

   logic [8:0]  mem [0:65535];
   logic        force_en;
   logic [8:0]  force_word;

   int n_cmp = 0;
   int n_err = 0;

   mem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
      .rdata(rdata), .parity_err(parity_err), .err_count(err_count),
      .mem_write(mem_write), .mem_read(mem_read), .mem_addr(mem_addr),
      .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
   );

   always #5 clk = ~clk;

   // Memory model: stores {~^data, data}; read word appears the cycle after.
   always @(posedge clk) begin
      if (mem_write) mem[mem_addr] <= {~^mem_data_in, mem_data_in};
      if (mem_read)  mem_data_out  <= force_en ? force_word : mem[mem_addr];
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_gnt(input bit p);
      int n = 0;
      tick();
      while (!(p ? gnt1 : gnt0) && n < 8) begin
         tick();
         n++;
      end
   endtask

   task automatic do_write(input bit p, input logic [15:0] a, input logic [7:0] d);
      if (p) begin req1 = 1; we1 = 1; addr1 = a; wdata1 = d; end
      else   begin req0 = 1; we0 = 1; addr0 = a; wdata0 = d; end
      wait_gnt(p);
      check("wr_gnt", p ? gnt1 : gnt0, 1);
      check("wr_strobe", {mem_write, mem_read}, 2'b10);
      check("wr_addr", mem_addr, a);
      check("wr_data", mem_data_in, d);
      req0 = 0; req1 = 0;
      tick();
   endtask

   // rvalid is expected exactly two cycles after the grant.
   task automatic do_read(input bit p, input logic [15:0] a, input logic [7:0] d, input bit perr);
      if (p) begin req1 = 1; we1 = 0; addr1 = a; end
      else   begin req0 = 1; we0 = 0; addr0 = a; end
      wait_gnt(p);
      check("rd_gnt", p ? gnt1 : gnt0, 1);
      check("rd_strobe", {mem_write, mem_read}, 2'b01);
      check("rd_addr", mem_addr, a);
      req0 = 0; req1 = 0;
      tick();
      tick();
      check("rd_rvalid", {rvalid1, rvalid0}, p ? 2'b10 : 2'b01);
      check("rd_data", rdata, d);
      check("rd_perr", parity_err, perr);
   endtask

   logic [15:0] sb_addr [100];
   logic [7:0]  sb_data [100];

   initial begin
      int g0, g1;
      logic [15:0] a;
      rst_n = 0; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
      addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
      force_en = 0; force_word = 0;
      #12;
      check("rst_gnt", {gnt1, gnt0}, 0);
      check("rst_rvalid", {rvalid1, rvalid0}, 0);
      check("rst_rdata", rdata, 0);
      check("rst_perr", parity_err, 0);
      check("rst_errcnt", err_count, 0);
      check("rst_strobes", {mem_write, mem_read}, 0);
      check("rst_addr", mem_addr, 0);
      check("rst_wdata", mem_data_in, 0);
      rst_n = 1;

      // Basic write then read back on port 0
      do_write(0, 16'h1234, 8'hA5);
      check("wr_strobe_off", {mem_write, mem_read}, 0);
      do_read(0, 16'h1234, 8'hA5, 0);

      // Continuous contention from a fresh reset: 0,1,0,1 every 2 cycles
      rst_n = 0; #1; rst_n = 1;
      g0 = 0; g1 = 0;
      req0 = 1; we0 = 1; addr0 = 16'h4000; wdata0 = 8'h00;
      req1 = 1; we1 = 1; addr1 = 16'h5000; wdata1 = 8'h80;
      for (int i = 1; i <= 200; i++) begin
         tick();
         check("rr_gnt0", gnt0, (i % 4) == 1);
         check("rr_gnt1", gnt1, (i % 4) == 3);
         check("rr_excl", mem_write & mem_read, 0);
         if (gnt0) begin g0++; addr0 = addr0 + 1; wdata0 = wdata0 + 1; end
         if (gnt1) begin g1++; addr1 = addr1 + 1; wdata1 = wdata1 + 1; end
      end
      req0 = 0; req1 = 0;
      check("rr_count0", g0, 50);
      check("rr_count1", g1, 50);

      // Random writes then read-back from random ports
      for (int i = 0; i < 100; i++) begin
         a = 16'($urandom);
         a[15:9] = i[6:0];
         sb_addr[i] = a;
         sb_data[i] = 8'($urandom);
         do_write(1'($urandom_range(0, 1)), sb_addr[i], sb_data[i]);
      end
      for (int i = 0; i < 100; i++)
         do_read(1'($urandom_range(0, 1)), sb_addr[i], sb_data[i], 0);
      check("rand_errcnt", err_count, 0);

      // Parity: 0x0A5 has an even count of ones (bad), 0x1A5 is good
      force_en = 1; force_word = 9'h0A5;
      do_read(0, 16'h0100, 8'hA5, 1);
      check("par_cnt1", err_count, 1);
      force_word = 9'h1A5;
      do_read(1, 16'h0100, 8'hA5, 0);
      check("par_cnt_hold", err_count, 1);
      force_word = 9'h0A5;
      for (int k = 0; k < 253; k++) do_read(0, 16'h0100, 8'hA5, 1);
      check("par_cnt254", err_count, 254);
      do_read(1, 16'h0100, 8'hA5, 1);
      check("par_cnt255", err_count, 255);
      for (int k = 0; k < 45; k++) do_read(0, 16'h0100, 8'hA5, 1);
      check("par_sat", err_count, 255);
      force_en = 0;

      // Reset during RESP of a read at 0x0010
      do_write(1, 16'h0010, 8'h3C);
      req0 = 1; we0 = 0; addr0 = 16'h0010;
      tick();
      check("rs_gnt", gnt0, 1);
      req0 = 0;
      tick();
      #2 rst_n = 0;
      #1;
      check("rs_strobes", {mem_write, mem_read}, 0);
      check("rs_valid", {gnt1, gnt0, rvalid1, rvalid0}, 0);
      check("rs_errcnt", err_count, 0);
      check("rs_addr", mem_addr, 0);
      check("rs_rdata", rdata, 0);
      #2 rst_n = 1;
      for (int k = 0; k < 4; k++) begin
         tick();
         check("rs_no_rvalid", {rvalid1, rvalid0}, 0);
      end
      req0 = 1; we0 = 0; addr0 = 16'h0010;
      req1 = 1; we1 = 1; addr1 = 16'h0020; wdata1 = 8'h77;
      tick();
      check("rs_prio", {gnt1, gnt0}, 2'b01);
      check("rs_rd_addr", mem_addr, 16'h0010);
      req0 = 0;
      tick();
      tick();
      check("rs_rvalid", {rvalid1, rvalid0}, 2'b01);
      check("rs_rd_data", rdata, 8'h3C);
      check("rs_gnt_idle", {gnt1, gnt0}, 0);
      tick();
      check("rs_gnt1", {gnt1, gnt0}, 2'b10);
      check("rs_wr", {mem_write, mem_addr}, {1'b1, 16'h0020});
      req1 = 0;
      tick();

      // After a port-0 grant, simultaneous port-1 write and port-0 read
      do_write(0, 16'h0040, 8'h11);
      req0 = 1; we0 = 0; addr0 = 16'h0020;
      req1 = 1; we1 = 1; addr1 = 16'h0030; wdata1 = 8'h5A;
      tick();
      check("mx_gnt1", {gnt1, gnt0}, 2'b10);
      check("mx_wr_addr", mem_addr, 16'h0030);
      req1 = 0;
      tick();
      check("mx_gap", {gnt1, gnt0}, 0);
      tick();
      check("mx_gnt0", {gnt1, gnt0}, 2'b01);
      check("mx_rd", {mem_read, mem_addr}, {1'b1, 16'h0020});
      req0 = 0;
      tick();
      check("mx_resp", {rvalid1, rvalid0}, 0);
      tick();
      check("mx_rvalid", {rvalid1, rvalid0}, 2'b01);
      check("mx_rdata", rdata, 8'h77);
      check("mx_perr", parity_err, 0);
      do_read(1, 16'h0030, 8'h5A, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
